// File: rtl/seq_muldiv_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage drives the master side; seq_muldiv implements the slave side.
interface seq_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_x;
  logic [WIDTH-1:0] data_y;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, data_x, data_y, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, data_x, data_y, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/seq_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Optional MULDIV_FAST_MULT_EN: multiplies use a single-cycle product and commit one edge later.
module seq_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input logic          clk,
  input logic          rst_n,
  seq_muldiv_if.slave  bus
);

  localparam int unsigned CntW = $clog2(ITER);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e r_state, w_state_d;

  logic [WIDTH-1:0] r_hi, r_lo;
  // r_acc:r_q is the shared product / remainder:quotient register pair
  logic [WIDTH-1:0] r_acc, r_q, r_m, r_x;
  logic             r_is_div, r_neg_q, r_neg_r, r_done;
  logic [CntW-1:0]  r_cnt;

  logic             w_busy, w_accept, w_md, w_is_mul, w_signed;
  logic             w_x_neg, w_y_neg;
  logic [WIDTH-1:0] w_x_mag, w_y_mag;
  logic             w_last_iter;

  assign w_md     = ~bus.op[2];
  assign w_is_mul = w_md & ~bus.op[1];
  assign w_signed = ~bus.op[0];
  assign w_accept = (r_state == StIdle) & bus.start & ~bus.flush;
  assign w_x_neg  = w_signed & bus.data_x[WIDTH-1];
  assign w_y_neg  = w_signed & bus.data_y[WIDTH-1];
  assign w_x_mag  = w_x_neg ? -bus.data_x : bus.data_x;
  assign w_y_mag  = w_y_neg ? -bus.data_y : bus.data_y;
  assign w_last_iter = (r_cnt == CntW'(ITER - 1));

  // Shift-add multiply step: add multiplicand when LSB set, then shift the pair right.
  logic [WIDTH:0] w_add;
  assign w_add = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);

  // Restoring divide step on the left-shifted partial remainder.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  assign w_shift = {r_acc, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_m});
  assign w_sub   = w_shift[WIDTH-1:0] - r_m;

  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;
  assign w_prod   = {r_acc, r_q};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;

  always_comb begin
    w_fix_hi = w_prod_s[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod_s[WIDTH-1:0];
    if (r_is_div) begin
      if (r_m == '0) begin
        w_fix_hi = r_x;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = r_neg_r ? -r_acc : r_acc;
        w_fix_lo = r_neg_q ? -r_q : r_q;
      end
    end
  end

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = (2*WIDTH)'(w_x_mag) * (2*WIDTH)'(w_y_mag);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept && w_md) begin
`ifdef MULDIV_FAST_MULT_EN
          w_state_d = w_is_mul ? StFix : StCalc;
`else
          w_state_d = StCalc;
`endif
        end
      end
      StCalc: begin
        if (bus.flush)        w_state_d = StIdle;
        else if (w_last_iter) w_state_d = StFix;
      end
      StFix:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_busy = (r_state != StIdle);
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_x      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (bus.op == 3'd4) r_hi <= bus.data_x;
            if (bus.op == 3'd5) r_lo <= bus.data_x;
            if (w_md) begin
              r_acc    <= '0;
              r_q      <= w_x_mag;
              r_m      <= w_y_mag;
              r_x      <= bus.data_x;
              r_is_div <= bus.op[1];
              r_neg_q  <= w_x_neg ^ w_y_neg;
              r_neg_r  <= w_x_neg;
              r_cnt    <= '0;
`ifdef MULDIV_FAST_MULT_EN
              if (w_is_mul) {r_acc, r_q} <= w_fast_prod;
`endif
            end
          end
        end
        StCalc: begin
          if (!bus.flush) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
              r_acc <= w_ge ? w_sub : w_shift[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], w_ge};
            end else begin
              r_acc <= w_add[WIDTH:1];
              r_q   <= {w_add[0], r_q[WIDTH-1:1]};
            end
          end
        end
        StFix: begin
          if (!bus.flush) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
